mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide engine that produces the HI/LO pair for MULT, MULTU, DIV and DIVU.
- Replaces the fixed-width HI/LO source in the multicycle datapath.
- The control unit pulses start, stalls on busy, and writes HI/LO registers from hi_out/lo_out when done is high.
- Supports any operand width and flags divide-by-zero for the exception path.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide engine.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO engine: shift-add multiply and restoring divide on operand
// magnitudes, with a final sign-fix step for MULT/DIV.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q, r_neg_r;
    logic               r_busy, r_done, r_dbz;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_accept, w_b_zero, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_madd, w_rsh, w_rdiff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mstep, w_dstep, w_acc_neg;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_b_zero = (bus.b_in == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // op[0]=0 selects the signed variants
    assign w_abs_a = (!bus.op[0] && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
    assign w_abs_b = (!bus.op[0] && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;

    // Multiply: multiplier sits in the low half and is consumed LSB first
    assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};
    assign w_mstep = {w_madd, r_acc[WIDTH-1:1]};

    // Divide: remainder in the high half, quotient bits shift into the low half
    assign w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge    = (w_rsh >= {1'b0, r_b});
    assign w_rdiff = w_rsh - {1'b0, r_b};
    assign w_dstep = {(w_ge ? w_rdiff[WIDTH-1:0] : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    assign w_acc_neg = -r_acc;

    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (!r_op[1]) begin
            if (r_neg_q) {w_fix_hi, w_fix_lo} = w_acc_neg;
        end else begin
            if (r_neg_q) w_fix_lo = -r_acc[WIDTH-1:0];
            if (r_neg_r) w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A DONE entered straight from IDLE (divide by zero) spends one cycle
    // raising done before it returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = (bus.op[1] && w_b_zero) ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (r_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= bus.op;
                    r_a     <= w_abs_a;
                    r_b     <= w_abs_b;
                    r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                    r_neg_q <= !bus.op[0] && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                    r_neg_r <= !bus.op[0] && bus.a_in[WIDTH-1];
                    r_cnt   <= '0;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b1;
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_DONE: begin
                    if (r_done) begin
                        r_done <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                        r_dbz  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi_out      = r_hi;
    assign bus.lo_out      = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) if32();
    mult_div_unit_if #(.WIDTH(8))  if8();

    mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vt[10];
    vec_t v8[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // start on the next falling edge, accept on the following rising edge,
    // then count edges until done is seen
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bc);
        @(negedge clk);
        if32.start = 1'b1; if32.op = op; if32.a_in = a; if32.b_in = b;
        @(posedge clk);
        @(negedge clk);
        if32.start = 1'b0; if32.a_in = $urandom; if32.b_in = $urandom;
        bc  = if32.busy ? 1 : 0;
        lat = 0;
        repeat (100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if32.done) break;
            if (if32.busy) bc++;
        end
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        if8.start = 1'b1; if8.op = op; if8.a_in = a; if8.b_in = b;
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        chk("w8_accept_busy", 64'(if8.busy), 64'd1);
        lat = 0;
        repeat (100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if8.done) break;
        end
    endtask

    initial begin
        int lat, bc, cnt;
        vt[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vt[1] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vt[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vt[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vt[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
        vt[5] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b0, 33};
        vt[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vt[7] = '{2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 33};
        vt[8] = '{2'b11, 32'd12345,    32'd0,        32'd5,        32'd0,        1'b1, 1};
        vt[9] = '{2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 33};

        v8[0] = '{2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, 9};
        v8[1] = '{2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 9};
        v8[2] = '{2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 9};

        if32.start = 1'b0; if32.op = 2'b00; if32.a_in = '0; if32.b_in = '0;
        if8.start  = 1'b0; if8.op  = 2'b00; if8.a_in  = '0; if8.b_in  = '0;

        #12;
        chk("rst_busy", 64'(if32.busy), 64'd0);
        chk("rst_done", 64'(if32.done), 64'd0);
        chk("rst_dbz",  64'(if32.div_by_zero), 64'd0);
        chk("rst_hilo", {if32.hi_out, if32.lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run32(vt[i].op, vt[i].a, vt[i].b, lat, bc);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vt[i].lat));
            chk($sformatf("v%0d_hi", i), 64'(if32.hi_out), 64'(vt[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(if32.lo_out), 64'(vt[i].lo));
            chk($sformatf("v%0d_dbz", i), 64'(if32.div_by_zero), 64'(vt[i].dbz));
        end

        // start held during the done cycle must not be taken until IDLE
        if32.start = 1'b1; if32.op = 2'b01; if32.a_in = 32'd3; if32.b_in = 32'd3;
        @(negedge clk);
        chk("done_cycle_start_ignored", 64'(if32.busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        if32.start = 1'b0;
        chk("idle_start_accepted", 64'(if32.busy), 64'd1);
        lat = 0;
        repeat (100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if32.done) break;
        end
        chk("late_start_latency", 64'(lat), 64'd33);
        chk("late_start_lo", 64'(if32.lo_out), 64'd9);

        // abort a MULTU mid-flight with a redundant start along the way
        @(negedge clk);
        if32.start = 1'b1; if32.op = 2'b01; if32.a_in = 32'd7; if32.b_in = 32'd9;
        @(posedge clk);
        @(negedge clk);
        if32.op = 2'b00; if32.a_in = 32'd5; if32.b_in = 32'd11;
        @(posedge clk);
        @(negedge clk);
        if32.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_abort_busy", 64'(if32.busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(if32.busy), 64'd0);
        chk("abort_done", 64'(if32.done), 64'd0);
        chk("abort_hilo", {if32.hi_out, if32.lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (if32.done || if32.busy) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);
        run32(2'b01, 32'd7, 32'd9, lat, bc);
        chk("fresh_latency", 64'(lat), 64'd33);
        chk("fresh_hilo", {if32.hi_out, if32.lo_out}, 64'd63);

        // WIDTH=8, back-to-back on the first IDLE cycle after each done
        for (int i = 0; i < 3; i++) begin
            run8(v8[i].op, v8[i].a[7:0], v8[i].b[7:0], lat);
            chk($sformatf("w8_%0d_latency", i), 64'(lat), 64'(v8[i].lat));
            chk($sformatf("w8_%0d_hi", i), 64'(if8.hi_out), 64'(v8[i].hi));
            chk($sformatf("w8_%0d_lo", i), 64'(if8.lo_out), 64'(v8[i].lo));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
